// File: rtl/cell_pkg.sv
// Shared definitions for the cell RAM arbiter.
// Holds the cell address width, cell data width, the starvation limit
// default, the owner encoding used for grants and read tags, and the
// read-tag record that travels down the two-stage return pipeline.
package cell_pkg;

    localparam int CELL_AW              = 16;  // {y[7:0], x[7:0]}
    localparam int CELL_W               = 4;   // one cell is a nibble
    localparam int STARVE_LIMIT_DEFAULT = 16;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        VID  = 2'd1,
        ENG  = 2'd2,
        LD   = 2'd3
    } owner_e;

    // One tag per granted access: who owns it and whether data comes back.
    typedef struct packed {
        owner_e owner;
        logic   rd;
    } tag_t;

endpackage

// File: rtl/cell_ram_arbiter_if.sv
// Bus bundle between the three cell RAM requesters, the cell RAM and the
// arbiter.
//
// Handshake: a requester raises req together with addr/we/din and holds
// all of them unchanged until the cycle in which its gnt is high; that
// cycle is the transfer. Nothing is queued for an ungranted requester.
// rvalid is a one-cycle strobe with no backpressure; rdata holds its last
// value while rvalid is low. ram_dout is the RAM read data and follows
// ram_addr by one cycle.
//
// master: requesters + RAM (drive req/addr/we/din and ram_dout)
// slave : arbiter (drives grants, read returns, RAM command, statistics)
interface cell_ram_arbiter_if
    import cell_pkg::*;
#(
    parameter int AW = CELL_AW
);
    logic              vid_req;
    logic [AW-1:0]     vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [CELL_W-1:0] vid_rdata;
    logic              vid_miss;

    logic              eng_req;
    logic              eng_we;
    logic [AW-1:0]     eng_addr;
    logic [CELL_W-1:0] eng_din;
    logic              eng_gnt;
    logic              eng_rvalid;
    logic [CELL_W-1:0] eng_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [AW-1:0]     ld_addr;
    logic [CELL_W-1:0] ld_din;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [CELL_W-1:0] ld_rdata;

    logic [AW-1:0]     ram_addr;
    logic              ram_we;
    logic [CELL_W-1:0] ram_din;
    logic [CELL_W-1:0] ram_dout;

    logic [15:0]       conflict_count;
    owner_e            dbg_rr_last;     // round-robin state, for observation

    modport master (
        output vid_req, vid_addr,
        output eng_req, eng_we, eng_addr, eng_din,
        output ld_req, ld_we, ld_addr, ld_din,
        output ram_dout,
        input  vid_gnt, vid_rvalid, vid_rdata, vid_miss,
        input  eng_gnt, eng_rvalid, eng_rdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  ram_addr, ram_we, ram_din,
        input  conflict_count, dbg_rr_last
    );

    modport slave (
        input  vid_req, vid_addr,
        input  eng_req, eng_we, eng_addr, eng_din,
        input  ld_req, ld_we, ld_addr, ld_din,
        input  ram_dout,
        output vid_gnt, vid_rvalid, vid_rdata, vid_miss,
        output eng_gnt, eng_rvalid, eng_rdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output ram_addr, ram_we, ram_din,
        output conflict_count, dbg_rr_last
    );

endinterface

// File: rtl/rr_starve_arb.sv
// Grant logic for the cell RAM: video has priority, engine and loader
// share a round-robin slot, and an engine/loader requester that has been
// denied STARVE_LIMIT consecutive cycles takes the slot from video.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   vid_req/eng_req/ld_req   requests
//   vid_gnt/eng_gnt/ld_gnt   one-hot (or zero) grants, combinational
//   vid_miss                 video was requesting but was preempted
//   rr_last                  last round-robin winner (ENG or LD)
module rr_starve_arb
    import cell_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
)
(
    input  logic   clk,
    input  logic   rst,
    input  logic   vid_req,
    input  logic   eng_req,
    input  logic   ld_req,
    output logic   vid_gnt,
    output logic   eng_gnt,
    output logic   ld_gnt,
    output logic   vid_miss,
    output owner_e rr_last
);

    localparam int              SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] eng_starve_q, eng_starve_d;
    logic [SW-1:0] ld_starve_q,  ld_starve_d;
    owner_e        rr_last_q,    rr_last_d;
    logic          eng_hot, ld_hot, tie_to_eng;

    assign eng_hot    = eng_req && (eng_starve_q >= LIMIT);
    assign ld_hot     = ld_req  && (ld_starve_q  >= LIMIT);
    // Loader won last time (or nobody yet) -> engine takes a tie.
    assign tie_to_eng = (rr_last_q == LD);
    assign rr_last    = rr_last_q;

    always_comb begin
        vid_gnt  = 1'b0;
        eng_gnt  = 1'b0;
        ld_gnt   = 1'b0;
        vid_miss = 1'b0;
        // Grants are forced low while reset is held.
        if (!rst) begin
            if (eng_hot && ld_hot) begin
                eng_gnt  = tie_to_eng;
                ld_gnt   = !tie_to_eng;
                vid_miss = vid_req;
            end else if (eng_hot) begin
                eng_gnt  = 1'b1;
                vid_miss = vid_req;
            end else if (ld_hot) begin
                ld_gnt   = 1'b1;
                vid_miss = vid_req;
            end else if (vid_req) begin
                vid_gnt  = 1'b1;
            end else if (eng_req && ld_req) begin
                eng_gnt  = tie_to_eng;
                ld_gnt   = !tie_to_eng;
            end else if (eng_req) begin
                eng_gnt  = 1'b1;
            end else if (ld_req) begin
                ld_gnt   = 1'b1;
            end
        end
    end

    // Starve counters: count denied cycles, clear on grant or idle. A
    // counter that loses a starved tie simply stays at the limit.
    always_comb begin
        eng_starve_d = eng_starve_q;
        ld_starve_d  = ld_starve_q;
        rr_last_d    = rr_last_q;

        if (!eng_req || eng_gnt)
            eng_starve_d = '0;
        else if (eng_starve_q < LIMIT)
            eng_starve_d = eng_starve_q + SW'(1);

        if (!ld_req || ld_gnt)
            ld_starve_d = '0;
        else if (ld_starve_q < LIMIT)
            ld_starve_d = ld_starve_q + SW'(1);

        if (eng_gnt)
            rr_last_d = ENG;
        else if (ld_gnt)
            rr_last_d = LD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_starve_q <= '0;
            ld_starve_q  <= '0;
            rr_last_q    <= LD;
        end else begin
            eng_starve_q <= eng_starve_d;
            ld_starve_q  <= ld_starve_d;
            rr_last_q    <= rr_last_d;
        end
    end

endmodule

// File: rtl/cell_ram_arbiter.sv
// Cell RAM arbiter: three requesters (video read-only, engine, loader)
// share one single-port cell RAM with one access per cycle.
//
// Timing for a grant in cycle N:
//   N    combinational grant
//   N+1  ram_addr/ram_we/ram_din carry the winner's command
//   N+2  owner's rvalid high, rdata = ram_dout (reads only)
//
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   cell_ram_arbiter_if.slave: requests, grants, read returns,
//         RAM command/data, conflict_count, round-robin debug state
module cell_ram_arbiter
    import cell_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int AW           = CELL_AW
)
(
    input  logic clk,
    input  logic rst,
    cell_ram_arbiter_if.slave bus
);

    logic [AW-1:0]     addr_q;
    logic              we_q;
    logic [CELL_W-1:0] din_q;
    tag_t              tag1_q, tag2_q;
    logic [15:0]       conflict_q;
    logic [CELL_W-1:0] vid_rd_q, eng_rd_q, ld_rd_q;
    logic              conflict;
    logic              vid_rv, eng_rv, ld_rv;

    rr_starve_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .vid_req  (bus.vid_req),
        .eng_req  (bus.eng_req),
        .ld_req   (bus.ld_req),
        .vid_gnt  (bus.vid_gnt),
        .eng_gnt  (bus.eng_gnt),
        .ld_gnt   (bus.ld_gnt),
        .vid_miss (bus.vid_miss),
        .rr_last  (bus.dbg_rr_last)
    );

    // Two or more requesters active in the same cycle.
    assign conflict = (bus.vid_req & bus.eng_req) |
                      (bus.vid_req & bus.ld_req)  |
                      (bus.eng_req & bus.ld_req);

    // Read return is decoded from the second tag stage, which lines up
    // with the RAM's one-cycle read latency.
    assign vid_rv = tag2_q.rd && (tag2_q.owner == VID);
    assign eng_rv = tag2_q.rd && (tag2_q.owner == ENG);
    assign ld_rv  = tag2_q.rd && (tag2_q.owner == LD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            din_q      <= '0;
            tag1_q     <= tag_t'{owner: NONE, rd: 1'b0};
            tag2_q     <= tag_t'{owner: NONE, rd: 1'b0};
            conflict_q <= '0;
            vid_rd_q   <= '0;
            eng_rd_q   <= '0;
            ld_rd_q    <= '0;
        end else begin
            // Without a grant the address/data registers hold.
            we_q   <= 1'b0;
            tag1_q <= tag_t'{owner: NONE, rd: 1'b0};
            if (bus.vid_gnt) begin
                addr_q <= bus.vid_addr;
                tag1_q <= tag_t'{owner: VID, rd: 1'b1};
            end else if (bus.eng_gnt) begin
                addr_q <= bus.eng_addr;
                we_q   <= bus.eng_we;
                din_q  <= bus.eng_din;
                tag1_q <= tag_t'{owner: ENG, rd: !bus.eng_we};
            end else if (bus.ld_gnt) begin
                addr_q <= bus.ld_addr;
                we_q   <= bus.ld_we;
                din_q  <= bus.ld_din;
                tag1_q <= tag_t'{owner: LD, rd: !bus.ld_we};
            end
            tag2_q <= tag1_q;

            if (conflict && (conflict_q != 16'hFFFF))
                conflict_q <= conflict_q + 16'd1;

            // Capture so rdata keeps its value once rvalid drops.
            if (vid_rv) vid_rd_q <= bus.ram_dout;
            if (eng_rv) eng_rd_q <= bus.ram_dout;
            if (ld_rv)  ld_rd_q  <= bus.ram_dout;
        end
    end

    assign bus.ram_addr       = addr_q;
    assign bus.ram_we         = we_q;
    assign bus.ram_din        = din_q;
    assign bus.conflict_count = conflict_q;

    assign bus.vid_rvalid = vid_rv;
    assign bus.eng_rvalid = eng_rv;
    assign bus.ld_rvalid  = ld_rv;
    assign bus.vid_rdata  = vid_rv ? bus.ram_dout : vid_rd_q;
    assign bus.eng_rdata  = eng_rv ? bus.ram_dout : eng_rd_q;
    assign bus.ld_rdata   = ld_rv  ? bus.ram_dout : ld_rd_q;

endmodule

// File: doc/cell_ram_arbiter.md
CELL_RAM_ARBITER -- requirements
Module: cell_ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 16, meaning consecutive denied cycles before an engine or loader requester preempts video.
REQ-002 SHALL have parameter AW, default 16, meaning cell address width ({y[7:0],x[7:0]}).
REQ-003 SHALL use one clock, clk; reset is rst, asynchronous and active-high.
REQ-004 Ports, as name / direction / width / meaning:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- vid_req  in  1  video read request; vid_addr  in  AW  video address.
- vid_gnt  out  1  video granted.
- vid_rvalid  out  1  video read data valid; vid_rdata  out  4  video read data.
- vid_miss  out  1  pulse when a video request is preempted.
- eng_req  in  1  engine request; eng_we  in  1  engine write; eng_addr  in  AW  engine address; eng_din  in  4  engine write data.
- eng_gnt  out  1  engine granted; eng_rvalid  out  1  engine read valid; eng_rdata  out  4  engine read data.
- ld_req  in  1  loader request; ld_we  in  1  loader write; ld_addr  in  AW  loader address; ld_din  in  4  loader write data.
- ld_gnt  out  1  loader granted; ld_rvalid  out  1  loader read valid; ld_rdata  out  4  loader read data.
- ram_addr  out  AW  cell RAM address; ram_we  out  1  cell RAM write enable; ram_din  out  4  cell RAM write data; ram_dout  in  4  cell RAM read data (1-cycle latency).
- conflict_count  out  16  saturating count of cycles with two or more simultaneous requests.

Function
REQ-005 Grants SHALL be combinational from the current requests and state; at most one gnt SHALL be high per cycle; a gnt SHALL be high only when the matching req is high.
REQ-006 Priority: video first; engine and loader share round-robin, with rr_last toggling to the granted one.
REQ-007 Preemption: a per-requester starve counter SHALL increment each cycle its req is high and its gnt is low.
REQ-008 When a starve counter reaches STARVE_LIMIT, that requester SHALL win over video for that cycle.
REQ-009 A preempted video cycle SHALL pulse vid_miss for one cycle.
REQ-010 When both engine and loader are starved in the same cycle, the rr_last rule SHALL apply.
REQ-011 A starve counter SHALL clear on its own grant, or when its req is low.
REQ-012 Pipeline, grant in cycle N: ram_addr, ram_we and ram_din SHALL register the winner's address, write strobe and data in N+1.
REQ-013 Pipeline, grant in cycle N: the owner rvalid SHALL be high in N+2 with rdata=ram_dout; writes SHALL produce no rvalid.
REQ-014 Owner/read tags SHALL form a 2-stage shift; back-to-back grants to different owners SHALL each return data to the correct owner every cycle (throughput 1 access/cycle).
REQ-015 With no grant, ram_we SHALL be 0 next cycle, and ram_addr/ram_din SHALL hold their last values.
REQ-016 Video SHALL always be treated as a read (vid write impossible); vid_rdata SHALL hold its value when vid_rvalid is low.
REQ-017 Requesters SHALL hold req/addr/we/din until gnt; the arbiter SHALL NOT buffer ungranted requests.
REQ-018 conflict_count SHALL saturate at 16'hFFFF.
REQ-019 A read and a write to the same address in consecutive grants SHALL return the pre-write value to the reader only if the read was granted first (no forwarding).

Reset
REQ-020 On rst, asynchronously: all gnt=0, all rvalid=0, vid_miss=0, ram_we=0, ram_addr=0, ram_din=0, all rdata=0, conflict_count=0, starve counters=0, tag pipeline cleared, rr_last=loader (engine wins first tie).
REQ-021 rst mid-transaction SHALL discard in-flight reads; no rvalid SHALL appear after reset release for pre-reset grants.

Structure
REQ-022 A shared package (cell_pkg) SHALL hold AW, the cell width (4), the owner encoding (NONE=0, VID=1, ENG=2, LD=3) and STARVE_LIMIT default.
REQ-023 The round-robin/starvation grant logic SHALL be one sub-module, rr_starve_arb; the datapath pipeline SHALL remain in cell_ram_arbiter.

Verification
REQ-024 Video-only reads at addr 0x0102, 0x0103 on consecutive cycles -> vid_gnt both cycles; vid_rvalid in N+2 and N+3 with preloaded values 5 then 3.
REQ-025 eng_req and ld_req held together, no video, 4 cycles -> grants E,L,E,L; conflict_count=4.
REQ-026 vid_req constant with eng_req held, STARVE_LIMIT=16 -> eng_gnt in cycle 17 only, vid_miss pulses once, then eng_starve resets to 0.
REQ-027 Loader write of 7 to 0x00FF in N, engine read of 0x00FF in N+1 -> ram_we=1 in N+1 only; eng_rvalid in N+3 with eng_rdata=7; no ld_rvalid.
REQ-028 rst asserted in the cycle after an engine read grant -> eng_rvalid stays 0 through 3 cycles after reset release; all outputs at their reset values.
REQ-029 Saturation: force 65536 conflict cycles -> conflict_count stays 16'hFFFF.
